// File: rtl/fetch_buffer.sv
// Instruction fetch front-end: owns the fetch PC, issues imem word reads and queues {inst, pc} in a small FIFO.
// Optional macro FETCH_BUF_BYPASS_EN lets a response arriving at an empty FIFO drive the outputs in the same cycle.
module fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  output logic                     imem_req_o,
  output logic [31:0]              imem_addr_o,
  input  logic [31:0]              imem_rdata_i,
  output logic                     inst_valid_o,
  input  logic                     inst_ready_i,
  output logic [31:0]              inst_o,
  output logic [31:0]              inst_pc_o,
  output logic [31:0]              inst_pc4_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int              PW      = $clog2(DEPTH);
  localparam int              CW      = PW + 1;
  localparam logic [CW:0]     DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_mem_inst [DEPTH];
  logic [31:0]   r_mem_pc   [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_infl;
  logic [31:0]   r_infl_pc;
  logic          r_infl_kill;

  logic [CW:0]   w_occ;
  logic          w_req;
  logic          w_resp;
  logic          w_bypass;
  logic          w_pop;
  logic          w_wr;
  logic          w_rd;
  logic          w_unused;

  assign w_unused = &{1'b0, redirect_pc_i[1:0]};

  // Registered count plus the in-flight slot: conservative, so the FIFO can never overflow.
  assign w_occ  = {1'b0, r_count} + {{CW{1'b0}}, r_infl};
  assign w_req  = !rst && !redirect_i && (w_occ < DEPTH_W);
  assign w_resp = r_infl && !r_infl_kill && !redirect_i;

`ifdef FETCH_BUF_BYPASS_EN
  assign w_bypass   = w_resp && (r_count == '0);
  assign inst_o     = w_bypass ? imem_rdata_i : r_mem_inst[r_rd_ptr];
  assign inst_pc_o  = w_bypass ? r_infl_pc    : r_mem_pc[r_rd_ptr];
`else
  assign w_bypass   = 1'b0;
  assign inst_o     = r_mem_inst[r_rd_ptr];
  assign inst_pc_o  = r_mem_pc[r_rd_ptr];
`endif

  assign inst_valid_o = (r_count != '0) || w_bypass;
  assign inst_pc4_o   = inst_pc_o + 32'd4;
  assign imem_req_o   = w_req;
  assign imem_addr_o  = r_fetch_pc;
  assign count_o      = r_count;

  // Redirect outranks both pop and push; a bypassed entry that is consumed is never stored.
  assign w_pop = inst_valid_o && inst_ready_i && !redirect_i;
  assign w_wr  = w_resp && !(w_bypass && w_pop);
  assign w_rd  = w_pop && !w_bypass;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc  <= RESET_PC;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_infl      <= 1'b0;
      r_infl_pc   <= '0;
      r_infl_kill <= 1'b0;
    end else begin
      r_infl      <= w_req;
      r_infl_kill <= redirect_i;
      if (w_req) begin
        r_infl_pc  <= r_fetch_pc;
      end
      if (redirect_i) begin
        r_fetch_pc <= {redirect_pc_i[31:2], 2'b00};
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
      end else begin
        if (w_req) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_wr) begin
          r_wr_ptr <= r_wr_ptr + PW'(1);
        end
        if (w_rd) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        case ({w_wr, w_rd})
          2'b10:   r_count <= r_count + CW'(1);
          2'b01:   r_count <= r_count - CW'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_inst[i] <= '0;
        r_mem_pc[i]   <= '0;
      end
    end else if (w_wr) begin
      r_mem_inst[r_wr_ptr] <= imem_rdata_i;
      r_mem_pc[r_wr_ptr]   <= r_infl_pc;
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: streaming, fill/drain, redirects, PC wrap and async reset.
module tb_fetch_buffer;

`ifdef FETCH_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int LAT = BYP ? 1 : 2;
  localparam logic [31:0] XK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        inst_ready_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic [31:0] rdata2 = '0;

  logic        imem_req_o, valid_o, req2, valid2;
  logic [31:0] imem_addr_o, inst_o, pc_o, pc4_o, addr2, inst2, pc2, pc42;
  logic [2:0]  count_o, count2;

  int checks = 0;
  int errors = 0;

  fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i),
    .inst_valid_o(valid_o), .inst_ready_i(inst_ready_i), .inst_o(inst_o),
    .inst_pc_o(pc_o), .inst_pc4_o(pc4_o), .count_o(count_o)
  );

  fetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut2 (
    .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(req2), .imem_addr_o(addr2), .imem_rdata_i(rdata2),
    .inst_valid_o(valid2), .inst_ready_i(inst_ready_i), .inst_o(inst2),
    .inst_pc_o(pc2), .inst_pc4_o(pc42), .count_o(count2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    imem_rdata_i <= imem_req_o ? (imem_addr_o ^ XK) : 32'hDEAD_BEEF;
    rdata2       <= req2 ? (addr2 ^ XK) : 32'hDEAD_BEEF;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit rdy, input bit rd, input logic [31:0] rpc);
    @(negedge clk);
    inst_ready_i  = rdy;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    #1;
  endtask

  task automatic do_reset(input bit rdy);
    @(negedge clk);
    rst = 1'b1;
    redirect_i = 1'b0;
    inst_ready_i = rdy;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   imem_req_o,  32'd0);
    chk({tag, "_addr"},  imem_addr_o, 32'h0);
    chk({tag, "_valid"}, valid_o,     32'd0);
    chk({tag, "_inst"},  inst_o,      32'h0);
    chk({tag, "_pc"},    pc_o,        32'h0);
    chk({tag, "_pc4"},   pc4_o,       32'h4);
    chk({tag, "_count"}, count_o,     32'd0);
  endtask

  initial begin
    logic [2:0] exp_cnt [10];
    logic       exp_req [10];
    logic [31:0] e;
    exp_cnt = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
    exp_req = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset values while held
    repeat (2) @(negedge clk);
    #1;
    chk_reset("rst0");
    chk("rst0_addr2", addr2, 32'hFFFF_FFF8);

    // Streaming with consumer always ready; second instance checks PC wrap
    do_reset(1'b1);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) cyc(1'b1, 1'b0, '0);
      chk("B_req", imem_req_o, 32'd1);
      chk("B_addr", imem_addr_o, 32'(4 * c));
      if (c < 4) begin
        chk("B_req2", req2, 32'd1);
        chk("B_wrap_addr2", addr2, 32'hFFFF_FFF8 + 32'(4 * c));
      end
      if (c >= LAT) begin
        e = 32'(4 * (c - LAT));
        chk("B_valid", valid_o, 32'd1);
        chk("B_pc", pc_o, e);
        chk("B_inst", inst_o, e ^ XK);
        chk("B_pc4", pc4_o, e + 32'd4);
      end else begin
        chk("B_valid_early", valid_o, 32'd0);
      end
    end

    // Fill with consumer stalled
    do_reset(1'b0);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) cyc(1'b0, 1'b0, '0);
      chk("D_count", count_o, 32'(exp_cnt[c]));
      chk("D_req", imem_req_o, 32'(exp_req[c]));
      if (exp_req[c]) chk("D_addr", imem_addr_o, 32'(4 * c));
    end

    // Drain in order
    for (int d = 0; d < 5; d++) begin
      cyc(1'b1, 1'b0, '0);
      chk("E_valid", valid_o, 32'd1);
      chk("E_pc", pc_o, 32'(4 * d));
      chk("E_inst", inst_o, 32'(4 * d) ^ XK);
      if (d < 3) chk("E_count", count_o, 32'(4 - d));
    end

    // Redirect with three entries queued and one request in flight
    do_reset(1'b0);
    repeat (3) cyc(1'b0, 1'b0, '0);
    cyc(1'b0, 1'b1, 32'h0000_0102);
    chk("F_count_pre", count_o, 32'd3);
    chk("F_req_redir", imem_req_o, 32'd0);
    cyc(1'b0, 1'b0, '0);
    chk("F_count_n1", count_o, 32'd0);
    chk("F_valid_n1", valid_o, 32'd0);
    chk("F_req_n1", imem_req_o, 32'd1);
    chk("F_addr_n1", imem_addr_o, 32'h0000_0100);
    cyc(1'b0, 1'b0, '0);
    chk("F_valid_n2", valid_o, 32'(BYP));
    if (BYP) chk("F_pc_n2", pc_o, 32'h0000_0100);
    cyc(1'b0, 1'b0, '0);
    chk("F_valid_n3", valid_o, 32'd1);
    chk("F_pc_n3", pc_o, 32'h0000_0100);
    chk("F_inst_n3", inst_o, 32'h0000_0100 ^ XK);
    chk("F_count_n3", count_o, 32'd1);

    // Redirect in the same cycle as a pop and a push
    do_reset(1'b1);
    repeat (2) cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b1, 32'h0000_0200);
    chk("G_valid_pre", valid_o, 32'd1);
    chk("G_pc_pre", pc_o, 32'(4 * (3 - LAT)));
    chk("G_req_redir", imem_req_o, 32'd0);
    cyc(1'b0, 1'b0, '0);
    chk("G_count_n1", count_o, 32'd0);
    chk("G_valid_n1", valid_o, 32'd0);
    chk("G_addr_n1", imem_addr_o, 32'h0000_0200);
    cyc(1'b0, 1'b0, '0);
    chk("G_count_n2", count_o, 32'd0);
    chk("G_valid_n2", valid_o, 32'(BYP));
    if (BYP) chk("G_pc_n2", pc_o, 32'h0000_0200);
    cyc(1'b0, 1'b0, '0);
    chk("G_valid_n3", valid_o, 32'd1);
    chk("G_pc_n3", pc_o, 32'h0000_0200);
    chk("G_count_n3", count_o, 32'd1);

    // Asynchronous reset mid-stream with three entries
    do_reset(1'b0);
    repeat (4) cyc(1'b0, 1'b0, '0);
    chk("H_count_pre", count_o, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk_reset("H_async");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("H_req_rel", imem_req_o, 32'd1);
    chk("H_addr_rel", imem_addr_o, 32'h0);
    chk("H_count_rel", count_o, 32'd0);
    cyc(1'b1, 1'b0, '0);
    chk("H_addr_c1", imem_addr_o, 32'h4);
    cyc(1'b1, 1'b0, '0);
    chk("H_pc_c2", pc_o, BYP ? 32'h4 : 32'h0);
    chk("H_valid_c2", valid_o, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
